// File: rtl/stripe_scheduler.sv
// stripe_scheduler: packs a serial symbol stream into 4-lane words,
// pads stalled partial words and inserts periodic SKP ordered sets.
module stripe_scheduler #(
    parameter int              BITS         = 8,
    parameter int              LANES        = 4,
    parameter int              SKP_INTERVAL = 16,
    parameter int              SKP_LEN      = 3,
    parameter logic [BITS-1:0] COM_SYM      = 8'hBC,
    parameter logic [BITS-1:0] SKP_SYM      = 8'h1C,
    parameter logic [BITS-1:0] PAD_SYM      = 8'hF7
) (
    input  logic             CLK,
    input  logic             RESET_L,
    input  logic [BITS-1:0]  IN_D,
    input  logic             IN_K,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [BITS-1:0]  LANE0,
    output logic [BITS-1:0]  LANE1,
    output logic [BITS-1:0]  LANE2,
    output logic [BITS-1:0]  LANE3,
    output logic [LANES-1:0] LANE_K,
    output logic             OUT_VALID,
    output logic             SKP_ACTIVE
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_COM,
        ST_SKP
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(SKP_INTERVAL - 1);
    localparam logic [2:0] SKP_LAST = 3'(SKP_LEN - 1);

    state_t                      r_state;
    logic [1:0]                  r_slot;
    logic [7:0]                  r_word_cnt;
    logic                        r_skp_pending;
    logic [2:0]                  r_skp_cnt;
    logic [BITS-1:0]             r_hold_d [LANES];
    logic [LANES-1:0]            r_hold_k;
    logic [LANES-1:0][BITS-1:0]  r_lane;
    logic [LANES-1:0]            r_lane_k;
    logic                        r_out_valid;
    logic                        r_skp_active;

    logic                        w_xfer;
    logic                        w_last;
    logic                        w_emit;
    logic [LANES-1:0][BITS-1:0]  w_word_d;
    logic [LANES-1:0]            w_word_k;

    assign IN_READY = (r_state == ST_RUN)
                   && !(r_skp_pending && r_slot == 2'd0);
    assign w_xfer   = IN_VALID && IN_READY;
    assign w_last   = (r_slot == 2'(LANES - 1));
    assign w_emit   = (r_state == ST_RUN)
                   && ((w_xfer && w_last) || (!IN_VALID && r_slot != 2'd0));

    // Slots below r_slot are held, the current slot takes the live
    // symbol, anything beyond is padding for a stalled partial word.
    always_comb begin
        w_word_d = '0;
        w_word_k = '0;
        for (int i = 0; i < LANES; i++) begin
            if (2'(i) < r_slot) begin
                w_word_d[i] = r_hold_d[i];
                w_word_k[i] = r_hold_k[i];
            end else if (2'(i) == r_slot && w_xfer) begin
                w_word_d[i] = IN_D;
                w_word_k[i] = IN_K;
            end else begin
                w_word_d[i] = PAD_SYM;
                w_word_k[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            r_state       <= ST_RUN;
            r_slot        <= '0;
            r_word_cnt    <= '0;
            r_skp_pending <= 1'b0;
            r_skp_cnt     <= '0;
            r_hold_k      <= '0;
            r_lane        <= '0;
            r_lane_k      <= '0;
            r_out_valid   <= 1'b0;
            r_skp_active  <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                r_hold_d[i] <= '0;
            end
        end else begin
            r_out_valid <= 1'b0;
            unique case (r_state)
                ST_RUN: begin
                    r_skp_active <= 1'b0;
                    if (r_skp_pending && r_slot == 2'd0) begin
                        r_state      <= ST_COM;
                        r_lane       <= {LANES{COM_SYM}};
                        r_lane_k     <= '1;
                        r_out_valid  <= 1'b1;
                        r_skp_active <= 1'b1;
                    end else begin
                        if (w_xfer && !w_last) begin
                            r_hold_d[r_slot] <= IN_D;
                            r_hold_k[r_slot] <= IN_K;
                            r_slot           <= r_slot + 2'd1;
                        end
                        if (w_emit) begin
                            r_lane      <= w_word_d;
                            r_lane_k    <= w_word_k;
                            r_out_valid <= 1'b1;
                            r_slot      <= '0;
                            if (r_word_cnt == LAST_CNT) begin
                                r_word_cnt    <= '0;
                                r_skp_pending <= 1'b1;
                            end else begin
                                r_word_cnt <= r_word_cnt + 8'd1;
                            end
                        end
                    end
                end
                ST_COM: begin
                    r_state      <= ST_SKP;
                    r_lane       <= {LANES{SKP_SYM}};
                    r_lane_k     <= '1;
                    r_out_valid  <= 1'b1;
                    r_skp_active <= 1'b1;
                    r_skp_cnt    <= SKP_LAST;
                end
                ST_SKP: begin
                    if (r_skp_cnt == 3'd0) begin
                        r_state       <= ST_RUN;
                        r_skp_pending <= 1'b0;
                        r_skp_active  <= 1'b0;
                    end else begin
                        r_skp_cnt    <= r_skp_cnt - 3'd1;
                        r_out_valid  <= 1'b1;
                        r_skp_active <= 1'b1;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign LANE0      = r_lane[0];
    assign LANE1      = r_lane[1];
    assign LANE2      = r_lane[2];
    assign LANE3      = r_lane[3];
    assign LANE_K     = r_lane_k;
    assign OUT_VALID  = r_out_valid;
    assign SKP_ACTIVE = r_skp_active;

endmodule

// File: tb/tb_stripe_scheduler.sv
// tb_stripe_scheduler: directed and random stimulus against a
// queue-based reference model of the striping/SKP rules.
module tb_stripe_scheduler;

    localparam int         SKP_INT = 2;
    localparam int         SLEN    = 3;
    localparam logic [7:0] COM     = 8'hBC;
    localparam logic [7:0] SKPS    = 8'h1C;
    localparam logic [7:0] PAD     = 8'hF7;

    logic       CLK = 1'b0;
    logic       RESET_L;
    logic [7:0] IN_D;
    logic       IN_K;
    logic       IN_VALID;
    logic       IN_READY;
    logic [7:0] LANE0, LANE1, LANE2, LANE3;
    logic [3:0] LANE_K;
    logic       OUT_VALID;
    logic       SKP_ACTIVE;

    int tests = 0;
    int fails = 0;

    stripe_scheduler #(
        .BITS         (8),
        .LANES        (4),
        .SKP_INTERVAL (SKP_INT),
        .SKP_LEN      (SLEN),
        .COM_SYM      (COM),
        .SKP_SYM      (SKPS),
        .PAD_SYM      (PAD)
    ) dut (
        .CLK        (CLK),
        .RESET_L    (RESET_L),
        .IN_D       (IN_D),
        .IN_K       (IN_K),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .LANE0      (LANE0),
        .LANE1      (LANE1),
        .LANE2      (LANE2),
        .LANE3      (LANE3),
        .LANE_K     (LANE_K),
        .OUT_VALID  (OUT_VALID),
        .SKP_ACTIVE (SKP_ACTIVE)
    );

    always #5 CLK = ~CLK;

    // Reference model: partial word as queues, expected outputs,
    // word count and position within an ordered set.
    logic [7:0]  pd[$];
    bit          pk[$];
    int          m_words;
    bit          m_pending;
    int          m_ospos;
    logic [31:0] e_lanes;
    logic [3:0]  e_k;
    bit          e_ov;
    bit          e_sa;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_ready();
        return !(m_pending && pd.size() == 0);
    endfunction

    task automatic m_reset();
        pd.delete();
        pk.delete();
        m_words   = 0;
        m_pending = 0;
        m_ospos   = 0;
        e_lanes   = '0;
        e_k       = '0;
        e_ov      = 0;
        e_sa      = 0;
    endtask

    task automatic m_step(input bit v, input logic [7:0] d, input bit k);
        if (m_pending && pd.size() == 0) begin
            if (m_ospos == 0) begin
                e_lanes = {4{COM}};
                e_k = 4'hF; e_ov = 1; e_sa = 1;
            end else if (m_ospos <= SLEN) begin
                e_lanes = {4{SKPS}};
                e_k = 4'hF; e_ov = 1; e_sa = 1;
            end else begin
                e_ov = 0; e_sa = 0; m_pending = 0;
            end
            m_ospos = (m_ospos == SLEN + 1) ? 0 : m_ospos + 1;
        end else begin
            e_ov = 0;
            e_sa = 0;
            if (v) begin
                pd.push_back(d);
                pk.push_back(k);
            end
            if (pd.size() == 4 || (!v && pd.size() > 0)) begin
                while (pd.size() < 4) begin
                    pd.push_back(PAD);
                    pk.push_back(1'b1);
                end
                for (int i = 0; i < 4; i++) begin
                    e_lanes[8*i +: 8] = pd[i];
                    e_k[i] = pk[i];
                end
                pd.delete();
                pk.delete();
                e_ov = 1;
                m_words++;
                if (m_words == SKP_INT) begin
                    m_pending = 1;
                    m_words = 0;
                end
            end
        end
    endtask

    task automatic check_outputs();
        chk("in_ready", IN_READY, m_ready());
        chk("out_valid", OUT_VALID, e_ov);
        chk("skp_active", SKP_ACTIVE, e_sa);
        chk("lanes", {LANE3, LANE2, LANE1, LANE0}, e_lanes);
        chk("lane_k", LANE_K, e_k);
    endtask

    task automatic cyc(input bit v, input logic [7:0] d, input bit k);
        check_outputs();
        IN_VALID = v;
        IN_D     = d;
        IN_K     = k;
        m_step(v, d, k);
        @(negedge CLK);
    endtask

    task automatic send(input logic [7:0] d, input bit k);
        bit r;
        int n = 0;
        do begin
            r = m_ready();
            cyc(1'b1, d, k);
            n++;
        end while (!r && n < 20);
        chk("send_accepted", r, 1'b1);
    endtask

    initial begin
        RESET_L  = 1'b0;
        IN_VALID = 1'b0;
        IN_D     = '0;
        IN_K     = 1'b0;
        m_reset();
        repeat (2) @(negedge CLK);
        chk("reset_lanes", {LANE3, LANE2, LANE1, LANE0}, 32'h0);
        chk("reset_ov", OUT_VALID, 1'b0);
        RESET_L = 1'b1;

        send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
        cyc(0, 8'h00, 0);
        send(8'h11, 0); send(8'h22, 0);
        cyc(0, 8'h00, 0);
        send(8'h01, 0); send(8'h02, 0); send(8'hBC, 1); send(8'h04, 0);
        for (int i = 0; i < 8; i++) begin
            send(8'(8'h30 + i), 0);
        end
        repeat (8) cyc(0, 8'h00, 0);

        send(8'hA1, 0); send(8'hA2, 0);
        IN_VALID = 1'b0;
        #2 RESET_L = 1'b0;
        #1;
        chk("async_lanes", {LANE3, LANE2, LANE1, LANE0}, 32'h0);
        chk("async_k", LANE_K, 4'h0);
        chk("async_ov", OUT_VALID, 1'b0);
        chk("async_sa", SKP_ACTIVE, 1'b0);
        m_reset();
        @(negedge CLK);
        RESET_L = 1'b1;
        send(8'h55, 0); send(8'h66, 0); send(8'h77, 0); send(8'h88, 0);

        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 4) != 0, 8'($urandom), ($urandom % 8) == 0);
        end
        repeat (10) cyc(0, 8'h00, 0);
        check_outputs();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stripe_scheduler.md
Name: stripe_scheduler

Overview:
- Front-end controller for the 4-lane byte-striping datapath.
- Accepts a serial byte stream with a valid/ready handshake and assembles one lane-word per LANES accepted bytes, with the first byte on LANE0.
- Pads partial words when the source stalls.
- Periodically inserts a SKP ordered set (COM + SKP symbols on all lanes) for clock compensation.
- Feeds lane-word plus per-lane K flags to the downstream lane serializers.

Parameters:
- BITS, 8, symbol width in bits.
- LANES, 4, number of lanes. Fixed at 4; any other value is unsupported.
- SKP_INTERVAL, 16, number of data lane-words emitted between SKP ordered sets (range 2..255).
- SKP_LEN, 3, number of SKP symbol cycles that follow the COM cycle (range 1..7).
- COM_SYM, 8'hBC, comma symbol (K28.5).
- SKP_SYM, 8'h1C, skip symbol (K28.0).
- PAD_SYM, 8'hF7, pad symbol (K23.7).

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RESET_L  in  1  asynchronous active-low reset.
- IN_D  in  BITS  input symbol.
- IN_K  in  1  input symbol is a control (K) character.
- IN_VALID  in  1  IN_D/IN_K valid this cycle.
- IN_READY  out  1  block accepts a symbol this cycle. Transfer occurs when IN_VALID && IN_READY.
- LANE0..LANE3  out  BITS each  striped lane symbols, registered.
- LANE_K  out  LANES  per-lane K flag; bit n belongs to LANEn, registered.
- OUT_VALID  out  1  lane-word valid; one-cycle pulse per word, registered.
- SKP_ACTIVE  out  1  high while an ordered set is on the lanes, registered.

Behaviour:
- Reset (RESET_L=0, async):
  - LANE0..3=0, LANE_K=0, OUT_VALID=0, SKP_ACTIVE=0.
  - slot=0, word_cnt=0, skp_pending=0, state=RUN.
  - Any partial word is discarded.
  - Release is synchronous to CLK. First transfer is possible on the first edge after release.
- State machine: RUN, COM, SKP.
- RUN:
  - IN_READY = !(skp_pending && slot==0).
  - On each transfer, the symbol is written to holding slot `slot`; slot increments.
  - On the transfer that fills slot LANES-1, the word (including that byte) is registered to LANE*/LANE_K with OUT_VALID=1 on the next edge, and slot returns to 0.
  - Latency: last byte accepted at edge N → OUT_VALID high for cycle N..N+1.
- Padding: in RUN, if IN_VALID=0 and slot>0, remaining slots are filled with PAD_SYM (K=1) and the word is emitted the same way. Slot returns to 0.
- Idle: IN_VALID=0 and slot==0 → OUT_VALID=0. Lanes hold their last value; LANE_K holds.
- word_cnt:
  - Increments on each emitted data word, padded words included.
  - When it reaches SKP_INTERVAL, skp_pending is set and word_cnt clears.
- SKP insertion:
  - Ordered sets are inserted only at word boundaries.
  - When skp_pending && slot==0, IN_READY=0 and the next edge enters COM.
  - If a word completes on the same edge that sets skp_pending, COM is entered on the following edge.
- COM: one cycle. All lanes = COM_SYM, LANE_K=all ones, OUT_VALID=1, SKP_ACTIVE=1. Next state is SKP.
- SKP:
  - SKP_LEN cycles. All lanes = SKP_SYM, LANE_K=all ones, OUT_VALID=1, SKP_ACTIVE=1.
  - A down-counter tracks the remaining cycles.
  - After the last SKP cycle, skp_pending clears and the state returns to RUN; IN_READY rises in that cycle.
- IN_READY is combinational from registered state only. It is 0 in COM and SKP, with no combinational path from IN_VALID.
- Ordered-set words do not increment word_cnt.
- The input K flag passes through unchanged to the corresponding LANE_K bit.
- Source stall mid-word at the same time as skp_pending: the pad completes the word first, then COM follows.

Test Plan:
- Reset then stream 0x01,0x02,0x03,0x04 on consecutive cycles → one cycle later: LANE0..3=01,02,03,04, LANE_K=0000, OUT_VALID=1 for exactly one cycle.
- Send 0x11,0x22 then drop IN_VALID → next word is LANE0..3=11,22,F7,F7 with LANE_K=1100 (LANE3,LANE2 bits set), OUT_VALID=1.
- SKP_INTERVAL=2, continuous valid stream of 8 bytes:
  - Two data words are emitted.
  - Then IN_READY=0 and one COM word (all BC, LANE_K=1111).
  - Then 3 SKP words (all 1C).
  - Then IN_READY=1 and the remaining bytes resume in order with none lost or duplicated.
- Input with IN_K=1 on byte 3 (0xBC) → LANE2=BC, LANE_K=0100, other lanes' K=0.
- Assert RESET_L=0 after 2 of 4 bytes → all outputs 0 immediately (async). After release, the next 4 bytes form a fresh word starting at LANE0.
- Hold IN_VALID=1 with IN_READY=0 during COM/SKP → the held symbol is accepted on the first RUN cycle and lands in LANE0 of the next word.
